// File: rtl/llc_stage_fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : llc_stage_fifo_pkg                                        |
// | Purpose  : Shared constants and helpers for the LLC inter-stage      |
// |            buffer (default depths per pipeline boundary, pointer     |
// |            width helper).                                            |
// | Ports    : none (package)                                            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package llc_stage_fifo_pkg;

   // Default depths for the individual LLC pipeline boundaries.
   localparam int LLC_FIFO_DEPTH_MEM    = 4;
   localparam int LLC_FIFO_DEPTH_LOOKUP = 4;
   localparam int LLC_FIFO_DEPTH_PROC   = 2;

   // Pointer width able to index 0..depth-1; never narrower than one bit.
   function automatic int fifo_ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/llc_fifo_ptr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : llc_fifo_ptr                                              |
// | Purpose  : Wrap-around index counter 0..DEPTH-1 with explicit wrap,  |
// |            used for the FIFO read and write pointers.                |
// | Ports    : clk, rst_n (async active-low), en (advance), clr (sync    |
// |            clear, wins over en), ptr (current index).                |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module llc_fifo_ptr
   import llc_stage_fifo_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = fifo_ptr_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   output logic [PTR_W-1:0] ptr
);

   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] ptr_d;

   // Wrap is explicit so non-power-of-two depths index correctly.
   always_comb begin
      ptr_d = ptr_q;
      if (clr) begin
         ptr_d = '0;
      end else if (en) begin
         ptr_d = (ptr_q == LAST_IDX) ? '0 : ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;

endmodule
`default_nettype wire

// File: rtl/llc_stage_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : llc_stage_fifo                                            |
// | Purpose  : Generic LLC inter-stage FIFO, FWFT or registered output,  |
// |            with occupancy, almost-full and sticky error flags.       |
// | Ports    : clk, rst_n (async active-low), flush (sync clear),        |
// |            push/data_in (write), pop (consume head),                 |
// |            data_out/valid_out (head or last popped payload),         |
// |            full, empty, almost_full, usage (from registered count),  |
// |            err_overflow, err_underflow (sticky until rst_n/flush).   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module llc_stage_fifo
   import llc_stage_fifo_pkg::*;
#(
   parameter int WIDTH     = 64,
   parameter int DEPTH     = 4,
   parameter int AF_THRESH = DEPTH - 1,
   parameter int FWFT      = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           data_in,
   input  logic                       pop,
   output logic [WIDTH-1:0]           data_out,
   output logic                       valid_out,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic [$clog2(DEPTH+1)-1:0] usage,
   output logic                       err_overflow,
   output logic                       err_underflow
);

   localparam int PTR_W = fifo_ptr_w(DEPTH);
   localparam int USE_W = $clog2(DEPTH + 1);
   localparam logic [USE_W-1:0] DEPTH_U = USE_W'(DEPTH);
   localparam logic [USE_W-1:0] AF_U    = USE_W'(AF_THRESH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [USE_W-1:0] usage_q, usage_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             push_acc, pop_acc;

   // Status comes only from the registered count, never from push/pop.
   assign full        = (usage_q == DEPTH_U);
   assign empty       = (usage_q == '0);
   assign almost_full = (usage_q >= AF_U);
   assign usage       = usage_q;

   // A pop at full frees its slot in the same cycle, so push is taken too.
   // flush overrides both.
   assign push_acc = !flush && push && (!full || pop);
   assign pop_acc  = !flush && pop && !empty;

   always_comb begin
      usage_d = usage_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      if (flush) begin
         usage_d = '0;
         ovf_d   = 1'b0;
         unf_d   = 1'b0;
      end else begin
         if (push_acc && !pop_acc) begin
            usage_d = usage_q + 1'b1;
         end else if (pop_acc && !push_acc) begin
            usage_d = usage_q - 1'b1;
         end
         if (push && !push_acc) begin
            ovf_d = 1'b1;
         end
         if (pop && empty) begin
            unf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         usage_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         usage_q <= usage_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Payload storage is intentionally left unreset.
   always_ff @(posedge clk) begin
      if (push_acc) begin
         mem_q[wr_ptr] <= data_in;
      end
   end

   llc_fifo_ptr #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_wr_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (push_acc),
      .clr   (flush),
      .ptr   (wr_ptr)
   );

   llc_fifo_ptr #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_rd_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (pop_acc),
      .clr   (flush),
      .ptr   (rd_ptr)
   );

   assign err_overflow  = ovf_q;
   assign err_underflow = unf_q;

   generate
      if (FWFT != 0) begin : g_fwft
         assign data_out  = mem_q[rd_ptr];
         assign valid_out = !empty;
      end else begin : g_reg_out
         logic [WIDTH-1:0] dout_q, dout_d;
         logic             vout_q, vout_d;

         // valid_out is a single-cycle pulse following each accepted pop;
         // pop_acc is already low during flush, which clears the pulse.
         always_comb begin
            dout_d = dout_q;
            vout_d = pop_acc;
            if (pop_acc) begin
               dout_d = mem_q[rd_ptr];
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               dout_q <= '0;
               vout_q <= 1'b0;
            end else begin
               dout_q <= dout_d;
               vout_q <= vout_d;
            end
         end

         assign data_out  = dout_q;
         assign valid_out = vout_q;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_llc_stage_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_llc_stage_fifo                                         |
// | Purpose  : Directed self-checking bench for llc_stage_fifo with      |
// |            three configurations: DEPTH=4/AF=2/FWFT, DEPTH=3/FWFT,    |
// |            DEPTH=2/registered output.                                |
// | Ports    : none                                                      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_llc_stage_fifo;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: DEPTH=4, AF_THRESH=2, FWFT
   logic       a_flush, a_push, a_pop;
   logic [7:0] a_din, a_dout;
   logic       a_vld, a_full, a_empty, a_af, a_ovf, a_unf;
   logic [2:0] a_use;

   // Instance B: DEPTH=3, FWFT
   logic       b_flush, b_push, b_pop;
   logic [7:0] b_din, b_dout;
   logic       b_vld, b_full, b_empty, b_af, b_ovf, b_unf;
   logic [1:0] b_use;

   // Instance C: DEPTH=2, registered output
   logic       c_flush, c_push, c_pop;
   logic [7:0] c_din, c_dout;
   logic       c_vld, c_full, c_empty, c_af, c_ovf, c_unf;
   logic [1:0] c_use;

   llc_stage_fifo #(.WIDTH(8), .DEPTH(4), .AF_THRESH(2), .FWFT(1)) u_a (
      .clk(clk), .rst_n(rst_n), .flush(a_flush), .push(a_push), .data_in(a_din),
      .pop(a_pop), .data_out(a_dout), .valid_out(a_vld), .full(a_full),
      .empty(a_empty), .almost_full(a_af), .usage(a_use),
      .err_overflow(a_ovf), .err_underflow(a_unf));

   llc_stage_fifo #(.WIDTH(8), .DEPTH(3), .FWFT(1)) u_b (
      .clk(clk), .rst_n(rst_n), .flush(b_flush), .push(b_push), .data_in(b_din),
      .pop(b_pop), .data_out(b_dout), .valid_out(b_vld), .full(b_full),
      .empty(b_empty), .almost_full(b_af), .usage(b_use),
      .err_overflow(b_ovf), .err_underflow(b_unf));

   llc_stage_fifo #(.WIDTH(8), .DEPTH(2), .FWFT(0)) u_c (
      .clk(clk), .rst_n(rst_n), .flush(c_flush), .push(c_push), .data_in(c_din),
      .pop(c_pop), .data_out(c_dout), .valid_out(c_vld), .full(c_full),
      .empty(c_empty), .almost_full(c_af), .usage(c_use),
      .err_overflow(c_ovf), .err_underflow(c_unf));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one active edge and settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      {a_flush, a_push, a_pop, a_din} = '0;
      {b_flush, b_push, b_pop, b_din} = '0;
      {c_flush, c_push, c_pop, c_din} = '0;
      tick();
      tick();

      // ---------------- reset values ----------------
      check("rst_a_usage", a_use, 0);
      check("rst_a_empty", a_empty, 1);
      check("rst_a_full", a_full, 0);
      check("rst_a_af", a_af, 0);
      check("rst_a_valid", a_vld, 0);
      check("rst_a_errs", {a_ovf, a_unf}, 0);
      check("rst_b_empty", b_empty, 1);
      check("rst_c_valid", c_vld, 0);
      check("rst_c_dout", c_dout, 0);
      check("rst_c_errs", {c_ovf, c_unf}, 0);
      rst_n = 1'b1;
      tick();

      // ---------------- A: fill 4 then drain in order ----------------
      a_push = 1; a_din = 8'h0A; tick();
      check("a_first_head", a_dout, 8'h0A);
      check("a_first_valid", a_vld, 1);
      check("a_use1", a_use, 1);
      a_din = 8'h0B; tick();
      check("a_af_at2", a_af, 1);
      a_din = 8'h0C; tick();
      a_din = 8'h0D; tick();
      check("a_full4", a_full, 1);
      check("a_use4", a_use, 4);
      a_push = 0; a_pop = 1;
      check("a_pop_A", a_dout, 8'h0A);
      tick();
      check("a_pop_B", a_dout, 8'h0B);
      check("a_use3", a_use, 3);
      check("a_notfull", a_full, 0);
      tick();
      check("a_pop_C", a_dout, 8'h0C);
      check("a_use2", a_use, 2);
      tick();
      check("a_pop_D", a_dout, 8'h0D);
      check("a_use1b", a_use, 1);
      tick();
      check("a_use0", a_use, 0);
      check("a_empty_again", a_empty, 1);
      check("a_no_unf", a_unf, 0);
      a_pop = 0;

      // ---------------- A: full push+pop, then overflow ----------------
      a_push = 1;
      a_din = 8'hE1; tick();
      a_din = 8'hE2; tick();
      a_din = 8'hE3; tick();
      a_din = 8'hE4; tick();
      check("a_full_again", a_full, 1);
      a_pop = 1; a_din = 8'hE5; tick();          // push+pop at full
      check("a_pp_use", a_use, 4);
      check("a_pp_noovf", a_ovf, 0);
      check("a_pp_head", a_dout, 8'hE2);
      a_pop = 0; a_din = 8'hEE; tick();          // rejected push
      check("a_ovf_set", a_ovf, 1);
      check("a_ovf_use", a_use, 4);
      a_push = 0; a_pop = 1;
      tick();
      check("a_drain_E3", a_dout, 8'hE3);
      tick();
      check("a_drain_E4", a_dout, 8'hE4);
      tick();
      check("a_drain_E5_last", a_dout, 8'hE5);
      tick();
      check("a_drain_empty", a_empty, 1);
      check("a_ovf_sticky", a_ovf, 1);

      // ---------------- A: underflow, pointers stay, flush clears ----------------
      tick();                                    // pop while empty
      check("a_unf_set", a_unf, 1);
      check("a_unf_use", a_use, 0);
      a_pop = 0; a_push = 1; a_din = 8'h4B; tick();
      check("a_unf_ptr_head", a_dout, 8'h4B);
      check("a_unf_use1", a_use, 1);
      a_push = 0; a_pop = 1; tick();
      check("a_unf_empty", a_empty, 1);
      a_pop = 0; a_flush = 1; tick();
      a_flush = 0;
      check("a_flush_unf", a_unf, 0);
      check("a_flush_ovf", a_ovf, 0);

      // ---------------- A: almost_full then flush with push+pop ----------------
      a_push = 1;
      a_din = 8'h61; tick();
      a_din = 8'h62; tick();
      a_din = 8'h63; tick();
      check("a_af_use3", a_use, 3);
      check("a_af_set", a_af, 1);
      a_flush = 1; a_pop = 1; a_din = 8'h99; tick();
      a_flush = 0; a_pop = 0;
      check("a_fl_use", a_use, 0);
      check("a_fl_empty", a_empty, 1);
      check("a_fl_af", a_af, 0);
      a_din = 8'h71; tick();
      check("a_fl_nostore_use", a_use, 1);
      check("a_fl_nostore_head", a_dout, 8'h71);
      a_din = 8'h72; tick();
      a_push = 0;
      check("a_use2_pre_rst", a_use, 2);

      // ---------------- B: DEPTH=3 wrap with single occupancy ----------------
      for (int i = 0; i < 10; i++) begin
         b_push = 1; b_pop = 0; b_din = 8'h10 + 8'(i); tick();
         check("b_head", b_dout, 8'h10 + 8'(i));
         check("b_use1", b_use, 1);
         b_push = 0; b_pop = 1; tick();
         check("b_use0", b_use, 0);
      end
      b_pop = 0;
      check("b_no_errs", {b_ovf, b_unf}, 0);

      // ---------------- C: registered output pulse ----------------
      c_push = 1; c_din = 8'h55; tick();
      c_push = 0;
      check("c_use1", c_use, 1);
      check("c_valid_before_pop", c_vld, 0);
      c_pop = 1; tick();                         // pop edge N
      c_pop = 0;
      check("c_dout_N1", c_dout, 8'h55);
      check("c_valid_N1", c_vld, 1);
      check("c_use0", c_use, 0);
      tick();
      check("c_valid_N2", c_vld, 0);
      check("c_dout_hold", c_dout, 8'h55);

      // ---------------- async reset mid-stream ----------------
      #2;
      rst_n = 1'b0;
      #1;                                        // well before the next edge
      check("arst_a_usage", a_use, 0);
      check("arst_a_empty", a_empty, 1);
      check("arst_a_valid", a_vld, 0);
      check("arst_c_dout", c_dout, 0);
      #2;
      rst_n = 1'b1;
      tick();
      check("arst_a_stay_empty", a_empty, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/llc_stage_fifo.md
# llc_stage_fifo

Parametrised inter-stage buffer for the LLC pipeline. It replaces the fixed per-stage FIFOs between the address decoder, local memory, way lookup and request processing with one generic block. It is generic in payload width and depth and selectable between first-word-fall-through and registered-output modes. It also adds an almost-full threshold, an exact occupancy count and sticky overflow/underflow flags for the core's stall and debug logic.

## Interface
- WIDTH, 64, payload bits; callers pack stage packets (fifo_mem_packet etc.) into a flat vector.
- DEPTH, 4, entries; any value ≥ 2, power of two not required.
- AF_THRESH, DEPTH-1, almost_full asserts when usage ≥ AF_THRESH; legal 1..DEPTH.
- FWFT, 1, 1 = head visible combinationally; 0 = registered output, one-cycle pop latency.
- clk  in  1  clock.
- rst  in  1  reset; one clock, reset asynchronous and active-low.
- flush  in  1  synchronous clear of contents and error flags.
- push  in  1  write data_in this cycle.
- data_in  in  WIDTH  write payload.
- pop  in  1  consume head this cycle.
- data_out  out  WIDTH  head payload (FWFT=1) or last popped payload (FWFT=0).
- valid_out  out  1  data_out meaningful.
- full  out  1  usage == DEPTH.
- empty  out  1  usage == 0.
- almost_full  out  1  usage ≥ AF_THRESH.
- usage  out  $clog2(DEPTH+1)  current occupancy.
- err_overflow  out  1  sticky: push rejected while full.
- err_underflow  out  1  sticky: pop while empty.

## Operation
- Storage is a DEPTH-entry array, written at wr_ptr and read at rd_ptr.
- Pointers advance modulo DEPTH: explicit wrap from DEPTH-1 to 0, with no reliance on binary overflow.
- Push is accepted when !full, or when full && pop is asserted in the same cycle.
- Pop is accepted when !empty.
- An accepted pop frees its slot in the same cycle, so push+pop at full keeps usage == DEPTH and both pointers advance.
- Push+pop at empty: the push is accepted and the pop is an underflow, leaving usage 1.
- usage is updated +1 on push only, −1 on pop only, and is unchanged on both or neither.
- A rejected push sets err_overflow and discards the data.
- A pop while empty sets err_underflow and leaves the pointers unchanged.
- The error flags clear only on rst or flush.
- FWFT=1: data_out = mem[rd_ptr] combinationally; valid_out = !empty.
- FWFT=0: data_out is a register loaded with mem[rd_ptr] on an accepted pop; valid_out is a one-cycle pulse in the cycle after that pop.
- flush has priority over push and pop in the same cycle. Both are ignored, pointers and usage go to 0, errors are cleared, and the FWFT=0 valid_out register is cleared.
- Storage array contents are not reset.

## Timing
- Reset values:
  - usage=0, empty=1, full=0.
  - almost_full=0 (AF_THRESH ≥ 1).
  - valid_out=0, errors=0, data_out=0 in FWFT=0 mode.
- Status outputs (full, empty, almost_full, usage) are registered or derived only from registered usage. They reflect the previous edge and never depend combinationally on push or pop.
- Write-to-read latency: with FWFT=1, data pushed at edge N is on data_out after edge N if the FIFO was empty. With FWFT=0, it is available one cycle after the pop edge.
- Reset mid-operation: asynchronous assertion immediately forces the reset values; deassertion is synchronous to the rising edge.
- No combinational path exists from pop to full, or from push to empty.

## Structure
- No new shared typedefs. Stage packet structs stay in cache_types.svh, and callers cast them via $bits.
- cache_consts.svh gains LLC_FIFO_DEPTH_MEM, LLC_FIFO_DEPTH_LOOKUP and LLC_FIFO_DEPTH_PROC defaults.
- One sub-module, llc_fifo_ptr: wrap-around counter (DEPTH, en, clr → ptr), instantiated for wr_ptr and rd_ptr.

## Test plan
- DEPTH=4, FWFT=1: push 0xA,0xB,0xC,0xD, then pop ×4:
  - data_out sequence A,B,C,D, with full=1 after the 4th push.
  - usage goes 4→0 and empty returns to 1.
- DEPTH=3 (non-power-of-two): 10 push/pop pairs interleaved with single-entry occupancy:
  - data order preserved across pointer wrap.
  - usage never exceeds 1.
- Full and push-only (DEPTH=4) → err_overflow=1 and the 5th data is lost. Full and push+pop → usage stays 4, no error, and the new entry emerges last.
- Empty and pop → err_underflow=1, pointers unchanged. A subsequent flush → err_underflow=0.
- FWFT=0, DEPTH=2: push 0x55, then pop at edge N → data_out=0x55 and valid_out=1 only in cycle N+1.
- Fill to 3 with AF_THRESH=2 (almost_full=1), then flush asserted together with push and pop:
  - next cycle usage=0, empty=1, almost_full=0.
  - the ignored push is not stored.
- Assert rst low mid-stream with usage=2 → outputs take reset values asynchronously, before the next clock edge.
